// File: rtl/program_loader.sv
// Boot-time program loader: assembles big-endian words from a byte stream and writes them to instruction memory.
// Optional trailing XOR checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  input  logic        reload,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memData,
  output logic        cpuHold,
  output logic        loadDone,
  output logic        loadError
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR_HI, HDR_LO, WORD, WRITE, DONE, ERROR, CHK} state_t;
  localparam state_t AFTER_DATA = CHK;
`else
  typedef enum logic [2:0] {HDR_HI, HDR_LO, WORD, WRITE, DONE, ERROR} state_t;
  localparam state_t AFTER_DATA = DONE;
`endif

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  state_t            state;
  logic [7:0]        hdr_hi;
  logic [15:0]       count;
  logic [ADDR_W:0]   idx;
  logic [1:0]        bcnt;
  logic [23:0]       word_acc;
  logic              take;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        xsum;
`endif

  function automatic logic [31:0] word_addr(input logic [ADDR_W:0] i);
    return BASE_ADDR + (32'(i) << 2);
  endfunction

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign byteReady = (state == HDR_HI) || (state == HDR_LO) || (state == WORD) || (state == CHK);
`else
  assign byteReady = (state == HDR_HI) || (state == HDR_LO) || (state == WORD);
`endif
  assign take      = byteValid & byteReady;
  assign memWrite  = (state == WRITE);
  assign cpuHold   = (state != DONE);
  assign loadDone  = (state == DONE);
  assign loadError = (state == ERROR);

  // Leading three bytes of the word in flight; the fourth is merged directly into memData.
  always_ff @(posedge clk) begin
    if (state == WORD && take) word_acc <= {word_acc[15:0], byteIn};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HDR_HI;
      hdr_hi  <= 8'h00;
      count   <= 16'h0000;
      idx     <= '0;
      bcnt    <= 2'd0;
      memAddr <= 32'h0000_0000;
      memData <= 32'h0000_0000;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xsum    <= 8'h00;
`endif
    end else begin
      case (state)
        HDR_HI: if (take) begin
          hdr_hi <= byteIn;
          state  <= HDR_LO;
        end
        HDR_LO: if (take) begin
          count <= {hdr_hi, byteIn};
          if ({hdr_hi, byteIn} == 16'h0000)           state <= AFTER_DATA;
          else if ({1'b0, hdr_hi, byteIn} > MAX_WORDS) state <= ERROR;
          else                                         state <= WORD;
        end
        WORD: if (take) begin
          bcnt <= bcnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          xsum <= xsum ^ byteIn;
`endif
          if (bcnt == 2'd3) begin
            memData <= {word_acc, byteIn};
            memAddr <= word_addr(idx);
            state   <= WRITE;
          end
        end
        WRITE: begin
          idx <= idx + 1'b1;
          if (16'(idx + 1'b1) == count) state <= AFTER_DATA;
          else                          state <= WORD;
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK: if (take) state <= (byteIn == xsum) ? DONE : ERROR;
`endif
        DONE, ERROR: if (reload) begin
          state <= HDR_HI;
          idx   <= '0;
          bcnt  <= 2'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          xsum  <= 8'h00;
`endif
        end
        default: state <= HDR_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: spec vector table, reset/reload/depth sequences and randomized images vs a stream model.
module tb_program_loader;
  localparam int          ADDR_W = 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          MAXW   = 1 << ADDR_W;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [7:0]  b [0:11];
    int          len;
    int          mode;
    bit          add_chk;
    bit          exp_done;
    int          exp_nwr;
    logic [31:0] exp_last_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byteIn = 8'h00;
  logic        byteValid = 1'b0;
  logic        reload = 1'b0;
  logic        byteReady, memWrite, cpuHold, loadDone, loadError;
  logic [31:0] memAddr, memData;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] exp_wr [$];
  bit          exp_done;
  bit          got_done;
  int          got_nwr;
  logic [31:0] held_addr = 32'h0;
  logic [31:0] held_data = 32'h0;

  program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
    .reload(reload), .memWrite(memWrite), .memAddr(memAddr), .memData(memData),
    .cpuHold(cpuHold), .loadDone(loadDone), .loadError(loadError)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] data_xor(input bq_t b, input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 4 * n; i++) x ^= b[2 + i];
    return x;
  endfunction

  // Reference: decode the image from the stream rules alone.
  task automatic model(input bq_t b);
    int n;
    exp_wr.delete();
    n = int'(b[0]) * 256 + int'(b[1]);
    if (n > MAXW) begin
      exp_done = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++)
      exp_wr.push_back({BASE + 32'(4 * i), b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]});
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    exp_done = (b[2 + 4 * n] == data_xor(b, n));
`else
    exp_done = 1'b1;
`endif
  endtask

  // Called at a negedge with the loader waiting for a header; mode 0 = valid held, 1 = every other cycle, 2 = random.
  task automatic run_image(input bq_t b, input int mode, input bit rnd_reload);
    int n, pos, acc, wr_now, wr_next, nwr, budget;
    bit big, end_now, end_next, offer, held, accept;
    n = int'(b[0]) * 256 + int'(b[1]);
    big = (n > MAXW);
    pos = 0; acc = 0; wr_now = -1; end_now = 1'b0; held = 1'b0; offer = 1'b0; nwr = 0;
    got_done = 1'b0;
    budget = 8 * b.size() + 40;
    for (int cyc = 0; ; cyc++) begin
      if (cyc >= budget) begin
        n_vec++; n_bad++;
        $display("FAIL timeout: loader not finished after %0d cycles, expected completion", cyc);
        break;
      end
      check("memWrite", 32'(memWrite), 32'(wr_now >= 0));
      if (wr_now >= 0) begin
        check("memAddr", memAddr, exp_wr[wr_now][63:32]);
        check("memData", memData, exp_wr[wr_now][31:0]);
        held_addr = exp_wr[wr_now][63:32];
        held_data = exp_wr[wr_now][31:0];
        nwr++;
      end
      check("end_flag", 32'(loadDone | loadError), 32'(end_now));
      if (end_now) begin
        check("loadDone", 32'(loadDone), 32'(exp_done));
        check("loadError", 32'(loadError), 32'(!exp_done));
        check("cpuHold_end", 32'(cpuHold), 32'(!exp_done));
        got_done = loadDone;
        break;
      end
      check("cpuHold", 32'(cpuHold), 32'd1);
      check("byteReady", 32'(byteReady), 32'(wr_now < 0));
      if (!held)
        offer = (pos < b.size()) &&
                (mode == 0 || (mode == 1 && cyc % 2 == 0) || (mode == 2 && $urandom % 2 == 1));
      byteValid = offer;
      byteIn    = offer ? b[pos] : 8'($urandom);
      reload    = rnd_reload ? 1'($urandom % 2) : 1'b0;
      accept    = offer && byteReady;
      held      = offer && !accept;
      wr_next   = -1;
      end_next  = 1'b0;
`ifndef PROGRAM_LOADER_CHECKSUM_EN
      if (wr_now >= 0 && wr_now == n - 1) end_next = 1'b1;
`endif
      if (accept) begin
        if (acc == 1) begin
          if (big) end_next = 1'b1;
`ifndef PROGRAM_LOADER_CHECKSUM_EN
          else if (n == 0) end_next = 1'b1;
`endif
        end else if (acc >= 2 && acc < 2 + 4 * n && (acc - 2) % 4 == 3) begin
          wr_next = (acc - 2) / 4;
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        else if (acc == 2 + 4 * n && !big) end_next = 1'b1;
`endif
        pos++;
        acc++;
      end
      @(posedge clk);
      @(negedge clk);
      wr_now  = wr_next;
      end_now = end_next;
    end
    byteValid = 1'b0;
    reload    = 1'b0;
    got_nwr   = nwr;
    check("write_count", 32'(nwr), 32'(exp_wr.size()));
    check("memAddr_hold", memAddr, held_addr);
    check("memData_hold", memData, held_data);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byteReady"}, 32'(byteReady), 32'd1);
    check({tag, "_cpuHold"},   32'(cpuHold),   32'd1);
    check({tag, "_memWrite"},  32'(memWrite),  32'd0);
    check({tag, "_memAddr"},   memAddr,        32'h0);
    check({tag, "_memData"},   memData,        32'h0);
    check({tag, "_loadDone"},  32'(loadDone),  32'd0);
    check({tag, "_loadError"}, 32'(loadError), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; byteValid = 1'b0; reload = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    held_addr = 32'h0;
    held_data = 32'h0;
    rst_n = 1'b1;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reload = 1'b0;
    check("reload_cpuHold",   32'(cpuHold),   32'd1);
    check("reload_loadDone",  32'(loadDone),  32'd0);
    check("reload_loadError", 32'(loadError), 32'd0);
    check("reload_byteReady", 32'(byteReady), 32'd1);
  endtask

  function automatic bq_t with_chk(input bq_t b);
    bq_t q = b;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    q.push_back(data_xor(b, int'(b[0]) * 256 + int'(b[1])));
`endif
    return q;
  endfunction

  vec_t v [0:6];
  int   nv;

  initial begin
    bq_t q;
    logic [7:0] pre [0:3];

    v[0].b = '{8'h00,8'h02,8'hDE,8'hAD,8'hBE,8'hEF,8'h01,8'h23,8'h45,8'h67,8'h00,8'h00};
    v[0].len = 10; v[0].mode = 0; v[0].add_chk = 1; v[0].exp_done = 1; v[0].exp_nwr = 2; v[0].exp_last_data = 32'h01234567;
    v[1] = v[0];
    v[1].mode = 1;
    v[2].b = '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    v[2].len = 2; v[2].mode = 0; v[2].add_chk = 1; v[2].exp_done = 1; v[2].exp_nwr = 0; v[2].exp_last_data = 32'h01234567;
    v[3].b = '{8'h00,8'h11,8'h55,8'h66,8'h77,8'h88,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    v[3].len = 6; v[3].mode = 0; v[3].add_chk = 0; v[3].exp_done = 0; v[3].exp_nwr = 0; v[3].exp_last_data = 32'h01234567;
    v[4].b = '{8'h00,8'h01,8'hCA,8'hFE,8'hBA,8'hBE,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
    v[4].len = 6; v[4].mode = 0; v[4].add_chk = 1; v[4].exp_done = 1; v[4].exp_nwr = 1; v[4].exp_last_data = 32'hCAFEBABE;
    nv = 5;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    v[5].b = '{8'h00,8'h01,8'h11,8'h22,8'h33,8'h44,8'h44,8'h00,8'h00,8'h00,8'h00,8'h00};
    v[5].len = 7; v[5].mode = 0; v[5].add_chk = 0; v[5].exp_done = 1; v[5].exp_nwr = 1; v[5].exp_last_data = 32'h11223344;
    v[6] = v[5];
    v[6].b[6] = 8'h45; v[6].exp_done = 0;
    nv = 7;
`endif

    do_reset();
    for (int i = 0; i < nv; i++) begin
      if (i > 0) do_reload();
      q.delete();
      for (int k = 0; k < v[i].len; k++) q.push_back(v[i].b[k]);
      if (v[i].add_chk) q = with_chk(q);
      model(q);
      run_image(q, v[i].mode, 1'b0);
      check($sformatf("vec%0d_done", i),   32'(got_done), 32'(v[i].exp_done));
      check($sformatf("vec%0d_nwr", i),    32'(got_nwr),  32'(v[i].exp_nwr));
      check($sformatf("vec%0d_data", i),   memData,       v[i].exp_last_data);
    end

    // Reset arriving while the third byte of the first word is on the bus.
    do_reload();
    pre = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    for (int k = 0; k < 4; k++) begin
      byteValid = 1'b1;
      byteIn    = pre[k];
      @(posedge clk);
      @(negedge clk);
    end
    byteIn = 8'hCC;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    held_addr = 32'h0;
    held_data = 32'h0;
    @(negedge clk);
    byteValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    q = with_chk(q);
    model(q);
    run_image(q, 0, 1'b0);
    check("post_reset_done", 32'(got_done), 32'd1);
    check("post_reset_addr", memAddr, BASE);
    check("post_reset_data", memData, 32'h12345678);

    // Image filling the whole memory.
    do_reload();
    q = '{8'h00, 8'(MAXW)};
    for (int k = 0; k < 4 * MAXW; k++) q.push_back(8'($urandom));
    q = with_chk(q);
    model(q);
    run_image(q, 2, 1'b0);
    check("depth_done", 32'(got_done), 32'd1);
    check("depth_last_addr", memAddr, BASE + 32'(4 * (MAXW - 1)));

    // Randomized images, with reload toggling while it must be ignored.
    for (int r = 0; r < 24; r++) begin
      int n, sel;
      do_reload();
      sel = int'($urandom % 6);
      case (sel)
        0:       n = 0;
        1:       n = MAXW + 1 + int'($urandom % 3);
        2:       n = int'($urandom_range(256, 65535));
        default: n = int'($urandom_range(1, MAXW));
      endcase
      q = '{8'(n >> 8), 8'(n)};
      if (n <= MAXW) begin
        for (int k = 0; k < 4 * n; k++) q.push_back(8'($urandom));
        q = with_chk(q);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if ($urandom % 4 == 0) q[q.size() - 1] = q[q.size() - 1] ^ 8'h01;
`endif
      end else begin
        for (int k = 0; k < 3; k++) q.push_back(8'($urandom));
      end
      model(q);
      run_image(q, int'($urandom % 3), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader for the pipelined MIPS32 core. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written into the instruction memory write port in turn. The fetch stage is held (`cpuHold`) until the image is completely loaded, so this block is the writer feeding the instruction memory that the fetch stage reads.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction memory depth in words is 2^ADDR_W.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first loaded word.

Ports:
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `byteIn` input 8: incoming stream byte.
- `byteValid` input 1: `byteIn` is valid.
- `byteReady` output 1: loader accepts a byte this cycle.
- `reload` input 1: restart a load from DONE or ERROR.
- `memWrite` output 1: instruction memory write strobe.
- `memAddr` output 32: byte address of the write.
- `memData` output 32: word being written.
- `cpuHold` output 1: freezes PC and IF/ID while high.
- `loadDone` output 1: image loaded successfully.
- `loadError` output 1: malformed image.

## Operation
- Stream format: 2-byte word count N (MSB first), then N words, each MSB first.
- States:
  - HDR_HI: take the high byte of N.
  - HDR_LO: take the low byte of N.
  - WORD: collect 4 bytes.
  - WRITE: issue one memory write.
  - DONE: load finished.
  - ERROR: load failed.
- A byte is accepted only on a rising edge with `byteValid & byteReady`. Bytes offered while `byteReady`=0 are not consumed, and the sender holds them.
- `byteReady` = 1 only in HDR_HI, HDR_LO and WORD (and CHK when the checksum feature is compiled in).
- HDR_LO transition on accept:
  - N = 0 → DONE.
  - N > 2^ADDR_W → ERROR.
  - otherwise → WORD.
- WORD: byte k (k = 0..3) is shifted into a 32-bit assembly register. The first byte ends up in bits [31:24]. The 4th accepted byte moves the state to WRITE.
- WRITE lasts exactly one cycle, with:
  - `memWrite`=1
  - `memAddr` = BASE_ADDR + 4·idx (idx is the word index, ADDR_W+1 bits wide, starting at 0)
  - `memData` = the assembled word.
  
  After the write, idx increments. If idx = N the state goes to DONE (or CHK); otherwise it returns to WORD.
- DONE: `loadDone`=1, `cpuHold`=0.
- ERROR: `loadError`=1, `cpuHold`=1.
- `reload`=1 in DONE or ERROR → HDR_HI. This clears idx, the flags and the byte counter, and raises `cpuHold` on the next cycle. `reload` is ignored in every other state.
- `memAddr` and `memData` hold their last values outside WRITE. `memWrite`=0 outside WRITE.

## Timing
- Reset values:
  - state = HDR_HI
  - `byteReady`=1
  - `cpuHold`=1
  - `memWrite`=0
  - `memAddr`=0, `memData`=0
  - `loadDone`=0, `loadError`=0
  - idx=0, byte counter=0
- Reset takes effect immediately whatever the state, including mid-word or during WRITE. Any partial word is discarded.
- With `byteValid` held high, each word costs 5 cycles: 4 accepts plus 1 WRITE. The write strobe appears in the cycle after the 4th byte is accepted.
- `loadDone` rises the cycle after the final WRITE (or after the CHK accept). `cpuHold` falls in that same cycle.
- Outputs are registered or decoded from state only. There is no combinational path from `byteValid` to `byteReady`.

## Configuration
- Macro `PROGRAM_LOADER_CHECKSUM_EN`.
- Defined:
  - A CHK state follows the last WRITE; N = 0 also goes to CHK.
  - One more byte is expected: the XOR of all data bytes (the header is excluded).
  - On accept in CHK: match → DONE, mismatch → ERROR.
  - The running XOR clears on reset and on `reload`.
- Undefined: no CHK state, no running XOR. The last WRITE goes straight to DONE.

## Test plan
- Reset mid-stream: assert `rst_n`=0 during byte 2 of word 1 → outputs return to reset values at once. A following full image of N=1 loads correctly at address 0.
- Nominal load: stream 00 02, DE AD BE EF, 01 23 45 67 with valid held high →
  - write 32'hDEADBEEF at address 0x0, cycle after its 4th byte;
  - write 32'h01234567 at address 0x4;
  - `loadDone`=1 and `cpuHold`=0 one cycle later.
- Backpressure and gaps: same image with `byteValid` toggled every other cycle → identical writes. No byte is accepted during WRITE, and the byte offered then is taken next cycle.
- Boundaries:
  - N=0 → DONE two cycles after reset, no `memWrite` (checksum build: DONE after checksum byte 00).
  - N=2^ADDR_W+1 → ERROR after the header, `cpuHold` stays 1.
  - N=2^ADDR_W → the last write lands at address BASE+4·(2^ADDR_W−1).
- Reload: after DONE, pulse `reload` and stream 00 01 CA FE BA BE → `cpuHold` rises, a single write of 32'hCAFEBABE lands at BASE_ADDR, then DONE.
- Checksum build: image 00 01 11 22 33 44 then 44 → DONE (11^22^33^44 = 44). The same image followed by 45 → ERROR.
